// File: rtl/cart_accum.sv
// Shopping-cart accumulator: edge-detected add/remove requests feed a price LIFO and running totals.
// Define CART_SYNC_EN for a 2-flop input synchronizer; otherwise a single input flop is used.
module cart_accum #(
  parameter int unsigned PRICE_W   = 8,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned MAX_ITEMS = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sw_add,
  input  logic                     sw_del,
  input  logic                     clr,
  input  logic [PRICE_W-1:0]       cur_unit_price,
  output logic [CNT_W-1:0]         total_num,
  output logic [PRICE_W+CNT_W-1:0] total_price,
  output logic [PRICE_W-1:0]       last_price,
  output logic                     full,
  output logic                     empty,
  output logic                     reject
);

  localparam int unsigned TotW   = PRICE_W + CNT_W;
  localparam int unsigned AddrW  = (MAX_ITEMS > 1) ? $clog2(MAX_ITEMS) : 1;
  localparam int unsigned MemD   = 2 ** AddrW;
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_ITEMS);

  logic add_sync_q, del_sync_q;
  logic add_hist_q, del_hist_q;
  logic add_evt, del_evt;

  logic [CNT_W-1:0]   count_q, count_d;
  logic [TotW-1:0]    price_q, price_d;
  logic               reject_q, reject_d;
  logic               push;

  logic [PRICE_W-1:0] mem [MemD];
  logic [AddrW-1:0]   wr_idx, top_idx;
  logic [PRICE_W-1:0] top_price;

  // Input path flops reset high so a request held across reset release is not an edge.
`ifdef CART_SYNC_EN
  logic add_meta_q, del_meta_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_meta_q <= 1'b1;
      del_meta_q <= 1'b1;
      add_sync_q <= 1'b1;
      del_sync_q <= 1'b1;
    end else begin
      add_meta_q <= sw_add;
      del_meta_q <= sw_del;
      add_sync_q <= add_meta_q;
      del_sync_q <= del_meta_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_sync_q <= 1'b1;
      del_sync_q <= 1'b1;
    end else begin
      add_sync_q <= sw_add;
      del_sync_q <= sw_del;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_hist_q <= 1'b1;
      del_hist_q <= 1'b1;
    end else begin
      add_hist_q <= add_sync_q;
      del_hist_q <= del_sync_q;
    end
  end

  assign add_evt = add_sync_q & ~add_hist_q;
  assign del_evt = del_sync_q & ~del_hist_q;

  assign full  = (count_q == MaxCnt);
  assign empty = (count_q == '0);

  // Modular arithmetic in AddrW bits keeps the index correct when count_q == 2**AddrW.
  assign wr_idx    = count_q[AddrW-1:0];
  assign top_idx   = wr_idx - AddrW'(1);
  assign top_price = mem[top_idx];

  always_comb begin
    count_d  = count_q;
    price_d  = price_q;
    reject_d = 1'b0;
    push     = 1'b0;
    if (clr) begin
      count_d = '0;
      price_d = '0;
    end else if (add_evt && del_evt) begin
      reject_d = 1'b1;
    end else if (add_evt) begin
      if (full) begin
        reject_d = 1'b1;
      end else begin
        push    = 1'b1;
        count_d = count_q + CNT_W'(1);
        price_d = price_q + TotW'(cur_unit_price);
      end
    end else if (del_evt) begin
      if (empty) begin
        reject_d = 1'b1;
      end else begin
        count_d = count_q - CNT_W'(1);
        price_d = price_q - TotW'(top_price);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      price_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      price_q  <= price_d;
      reject_q <= reject_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx] <= cur_unit_price;
    end
  end

  assign total_num   = count_q;
  assign total_price = price_q;
  assign last_price  = empty ? '0 : top_price;
  assign reject      = reject_q;

endmodule

// File: tb/tb_cart_accum.sv
// Directed table-driven bench for cart_accum with a 3-item cart, plus hand sequences
// for clear collisions, update latency and requests held across reset.
module tb_cart_accum;

  localparam int unsigned PRICE_W   = 8;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned MAX_ITEMS = 3;
`ifdef CART_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     sw_add, sw_del, clr;
  logic [PRICE_W-1:0]       cur_unit_price;
  logic [CNT_W-1:0]         total_num;
  logic [PRICE_W+CNT_W-1:0] total_price;
  logic [PRICE_W-1:0]       last_price;
  logic                     full, empty, reject;

  int n_vec = 0;
  int n_bad = 0;

  cart_accum #(
    .PRICE_W   (PRICE_W),
    .CNT_W     (CNT_W),
    .MAX_ITEMS (MAX_ITEMS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sw_add         (sw_add),
    .sw_del         (sw_del),
    .clr            (clr),
    .cur_unit_price (cur_unit_price),
    .total_num      (total_num),
    .total_price    (total_price),
    .last_price     (last_price),
    .full           (full),
    .empty          (empty),
    .reject         (reject)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic add;
    logic del;
    int   price;
    int   num;
    int   tot;
    int   last;
    logic full;
    logic empty;
    logic rej;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int num, input int tot, input int last,
                           input logic f, input logic e, input logic r);
    chk({tag, ".num"},    int'(total_num),   num);
    chk({tag, ".price"},  int'(total_price), tot);
    chk({tag, ".last"},   int'(last_price),  last);
    chk({tag, ".full"},   int'(full),        int'(f));
    chk({tag, ".empty"},  int'(empty),       int'(e));
    chk({tag, ".reject"}, int'(reject),      int'(r));
  endtask

  // Drop all requests and let the history flops see the low level.
  task automatic idle();
    @(negedge clk);
    sw_add = 1'b0;
    sw_del = 1'b0;
    clr    = 1'b0;
    repeat (LAT + 2) @(posedge clk);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0,  10, 1,  10,  10, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0,  20, 2,  30,  20, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0,  30, 3,  60,  30, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1,   0, 2,  30,  20, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1,   0, 1,  10,  10, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1,   0, 0,   0,   0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1,   0, 0,   0,   0, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b1,  44, 0,   0,   0, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 255, 1, 255, 255, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 255, 2, 510, 255, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 255, 3, 765, 255, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 255, 3, 765, 255, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b1,   0, 2, 510, 255, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0,   0, 3, 510,   0, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1,   0, 2, 510, 255, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b1,   7, 2, 510, 255, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b1,   0, 1, 255, 255, 1'b0, 1'b0, 1'b0};

    rst            = 1'b0;
    sw_add         = 1'b0;
    sw_del         = 1'b0;
    clr            = 1'b0;
    cur_unit_price = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_state("reset", 0, 0, 0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (LAT + 2) @(posedge clk);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      sw_add         = tbl[i].add;
      sw_del         = tbl[i].del;
      cur_unit_price = PRICE_W'(tbl[i].price);
      repeat (LAT + 1) @(posedge clk);
      #1;
      chk_state($sformatf("vec%0d", i), tbl[i].num, tbl[i].tot, tbl[i].last,
                tbl[i].full, tbl[i].empty, tbl[i].rej);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.reject_drop", i), int'(reject), 0);
      idle();
    end

    // Two items stored (1 left from the table + one more), then clr collides with an add event.
    @(negedge clk);
    sw_add         = 1'b1;
    cur_unit_price = 8'd5;
    repeat (LAT + 1) @(posedge clk);
    #1;
    chk("pre_clr.num", int'(total_num), 2);
    idle();
    @(negedge clk);
    sw_add         = 1'b1;
    cur_unit_price = 8'd9;
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk_state("clr_hit", 0, 0, 0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;
    chk_state("clr_after", 0, 0, 0, 1'b0, 1'b1, 1'b0);
    idle();

    // Update latency: nothing visible before edge k+LAT.
    @(negedge clk);
    sw_add         = 1'b1;
    cur_unit_price = 8'd12;
    for (int j = 0; j < LAT; j++) begin
      @(posedge clk);
      #1;
      chk($sformatf("lat_early%0d", j), int'(total_num), 0);
    end
    @(posedge clk);
    #1;
    chk("lat_update.num", int'(total_num), 1);
    chk("lat_update.price", int'(total_price), 12);
    idle();

    // Asynchronous reset mid-operation with sw_add held high through release.
    @(negedge clk);
    sw_add         = 1'b1;
    cur_unit_price = 8'd4;
    #2;
    rst = 1'b0;
    #1;
    chk_state("async_rst", 0, 0, 0, 1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (LAT + 3) @(posedge clk);
    #1;
    chk("held_rst.num", int'(total_num), 0);
    chk("held_rst.reject", int'(reject), 0);
    idle();
    @(negedge clk);
    sw_add = 1'b1;
    repeat (LAT + 1) @(posedge clk);
    #1;
    chk_state("rearm", 1, 4, 4, 1'b0, 1'b0, 1'b0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
